// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory-interface types and constants
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake state reported by the memory model / controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2,
        RESP = 2'd3
    } mresp_state_t;

    // Load data returned when a request times out.
    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter with clear, enable and expire flag
//
// clk     : clock
// rst     : synchronous active-high reset
// clear   : force count to zero (has priority over enable)
// enable  : count one wait cycle
// expired : count has reached WAIT_MAX-1
module mem_wait_timer #(
    parameter int WAIT_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(WAIT_MAX) + 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;

    // No saturation: the owner leaves the request state once LAST is seen.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - arbitrates I-fetch and data requests onto one RAM port
//
// CLK, RST               : clock, synchronous active-high reset
// halt                   : blocks new instruction-fetch grants
// iREN, iaddr            : instruction read request
// dREN, dWEN, daddr, dstore : data read/write request
// ihit, dhit             : one-cycle completion pulses
// iload, dload           : returned instruction/data, held until next own hit
// ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate : RAM port
// mem_err                : sticky error (timeout or dREN&dWEN together)
module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int    WAIT_MAX = 64,
    parameter word_t ERR_WORD = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    mresp_state_t state_q, state_d;
    ramstate_t    rs;

    // Latched request: the RAM port is driven only from these.
    logic        data_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;

    logic in_req;
    logic access;
    logic timeout;
    logic expired;

    assign rs      = ramstate_t'(ramstate);
    assign in_req  = (state_q == DREQ) || (state_q == IREQ);
    assign access  = in_req && (rs == ACCESS);
    // ACCESS on the final allowed cycle still counts as a normal completion.
    assign timeout = in_req && !access && expired;

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .clear   (!in_req),
        .enable  (in_req && (rs != ACCESS)),
        .expired (expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    state_d = DREQ;
                end else if (iREN && !halt) begin
                    state_d = IREQ;
                end
            end
            DREQ: begin
                ramREN   = !wr_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = wr_q ? store_q : '0;
                if (access || timeout) begin
                    state_d = RESP;
                end
            end
            IREQ: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (access || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ihit    = !data_q;
                dhit    = data_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            iload   <= '0;
            dload   <= '0;
            mem_err <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (dREN || dWEN) begin
                    data_q  <= 1'b1;
                    wr_q    <= dWEN;
                    addr_q  <= daddr;
                    store_q <= dstore;
                    if (dREN && dWEN) begin
                        mem_err <= 1'b1;
                    end
                end else if (iREN && !halt) begin
                    data_q  <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= iaddr;
                    store_q <= '0;
                end
            end
            if (access || timeout) begin
                if (state_q == DREQ && !wr_q) begin
                    dload <= access ? ramload : ERR_WORD;
                end
                if (state_q == IREQ) begin
                    iload <= access ? ramload : ERR_WORD;
                end
                if (timeout) begin
                    mem_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipelined CPU.
- Accepts instruction-fetch and data load/store requests from the datapath and arbitrates them onto the single RAM port.
- Produces the ihit/dhit pulses and load data that the hazard unit and pipeline consume.
- Data requests have priority over instruction fetches; one RAM transaction is outstanding at a time.

Parameters:
- WAIT_MAX, 64: cycles allowed in a request state without ramstate==ACCESS before the timeout path fires.
- ERR_WORD, 32'hBAD1BAD1: load data returned on timeout.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- halt  in  1  CPU halted; no new instruction fetches granted
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  store data
- ihit  out  1  one-cycle instruction completion pulse
- dhit  out  1  one-cycle data completion pulse
- iload  out  32  fetched instruction, held until next ihit
- dload  out  32  loaded data, held until next dhit
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR (ramstate_t)
- mem_err  out  1  sticky error flag: timeout or dREN&dWEN together

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, wait counter 0, latched request cleared.
- FSM states: IDLE, DREQ, IREQ, RESP.
- IDLE grant, priority in this order:
  - (dREN|dWEN) -> DREQ. Latch daddr, dstore and the op. dWEN wins if both are set, and mem_err is set.
  - else iREN & !halt -> IREQ. Latch iaddr.
  - else stay in IDLE.
- DREQ/IREQ:
  - ramREN/ramWEN/ramaddr/ramstore are driven from the latched request only, not from live inputs.
  - ramstate==ACCESS: capture ramload into dload/iload (reads only), go to RESP.
  - ramstate==ERROR: stay in state and re-issue the same request. The counter keeps running.
  - FREE/BUSY: stay in state; counter increments.
  - counter==WAIT_MAX-1 with no ACCESS: load ERR_WORD (reads), set mem_err, go to RESP.
- RESP:
  - Exactly one cycle; ihit or dhit=1 matching the served request.
  - RAM enables 0; counter cleared; next state IDLE.
- Latency:
  - Request seen in IDLE at cycle N; RAM enable at N+1.
  - ACCESS at N+1 gives hit at N+2. Every RAM wait cycle adds one.
- Hit pulses: never both high in the same cycle; never high two consecutive cycles.
- Loads: iload/dload change only on the capture edge of their own request.
- Request changes: live inputs changing during DREQ/IREQ are ignored. A request withdrawn mid-transaction still completes.
- Halt:
  - halt blocks new IREQ grants only.
  - An IREQ already in flight completes.
  - Data requests are still served.
- Reset mid-transaction: RAM enables drop on the next edge; FSM returns to IDLE; the pending transaction is discarded with no hit.
- Clearing mem_err: only RST clears it.
- Counter width: $clog2(WAIT_MAX)+1; saturation is not needed because of the exit at WAIT_MAX-1.

Decomposition:
- cpu_types_pkg: ramstate_t and word_t (existing), plus new mresp_state_t enum {IDLE, DREQ, IREQ, RESP}.
- ERR_WORD default constant also lives in cpu_types_pkg.
- Sub-module mem_wait_timer: counter with clear, enable and expire output, parameterized by WAIT_MAX.

Test Plan:
- Ordered requests:
  - Reset, then iREN=1, iaddr=0x0.
  - RAM gives ACCESS on the first cycle with ramload=0x8C220004.
  - Expect ihit pulse 2 cycles after the request and iload=0x8C220004.
- Priority:
  - iREN=1 and dREN=1 same cycle, daddr=0x100.
  - Expect DREQ first (ramaddr=0x100, ramREN=1), dhit, then IREQ and ihit at least 3 cycles later.
  - ihit and dhit never overlap.
- RAM wait and error:
  - dWEN=1, daddr=0x200, dstore=0xDEADBEEF.
  - RAM shows BUSY 3 cycles, ERROR 1, then ACCESS.
  - Expect ramWEN held with constant address/data throughout; dhit at request+6; mem_err=0.
- Timeout:
  - dREN=1, RAM stuck BUSY, WAIT_MAX=8.
  - Expect dhit after 8 wait cycles, dload=0xBAD1BAD1, mem_err=1 and staying 1.
- Halt:
  - halt=1 while iREN=1 in IDLE: expect no ramREN and no ihit for 20 cycles.
  - dREN still served.
- Reset mid-transaction:
  - RST asserted one cycle in DREQ.
  - Expect ramREN=0 next cycle, no dhit, state IDLE, dload=0.
